successive_approx_controller: RTL and testbench

Successive-approximation ADC engine for the successive R2R and successive PWM measurement modes. It is the consumer of `enable_r2r_successive` and `enable_pwm_successive`. It drives a trial code onto the R2R ladder, or a PWM duty cycle into the RC filter. After a settle interval it samples the external comparator, resolves one bit per step from MSB to LSB, and publishes an averaged-free raw code to the display/scaling path.

---
 rtl/successive_approx_controller_pkg.sv | 29 ++
 rtl/successive_approx_controller_if.sv | 36 +++
 rtl/successive_approx_controller_pwm.sv | 24 ++
 rtl/successive_approx_controller.sv | 145 ++++++++++++++
 tb/tb_successive_approx_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/successive_approx_controller_pkg.sv
// Shared types and defaults for the successive-approximation ADC engine.
// Holds the FSM state and measurement-mode enums plus settle defaults.
package sar_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_BIT,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } sar_state_t;

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_R2R,
        MODE_PWM
    } sar_mode_t;

    localparam int R2R_SETTLE_DEFAULT = 1000;
    localparam int PWM_SETTLE_DEFAULT = 500000;

    // R2R wins when both enables are high.
    function automatic sar_mode_t pick_mode(logic r2r, logic pwm);
        if (r2r) return MODE_R2R;
        if (pwm) return MODE_PWM;
        return MODE_OFF;
    endfunction

endpackage

// File: rtl/successive_approx_controller_if.sv
// Enable, comparator and result bundle of the SAR ADC engine.
// master is the converter side, slave the measurement/display side.
interface successive_approx_controller_if #(
    parameter int WIDTH = 8
);
    logic             enable_r2r_successive;
    logic             enable_pwm_successive;
    logic             comp_in;
    logic [WIDTH-1:0] r2r_out;
    logic             pwm_out;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             busy;

    modport master (
        input  enable_r2r_successive,
        input  enable_pwm_successive,
        input  comp_in,
        output r2r_out,
        output pwm_out,
        output result,
        output result_valid,
        output busy
    );

    modport slave (
        output enable_r2r_successive,
        output enable_pwm_successive,
        output comp_in,
        input  r2r_out,
        input  pwm_out,
        input  result,
        input  result_valid,
        input  busy
    );
endinterface

// File: rtl/successive_approx_controller_pwm.sv
// Free-running PWM generator feeding the RC filter DAC.
// Period is 2^WIDTH cycles; output high while counter < duty.
module pwm_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            pwm_out <= 1'b0;
        end else begin
            count   <= count + WIDTH'(1);
            pwm_out <= (count < duty);
        end
    end

endmodule

// File: rtl/successive_approx_controller.sv
// SAR conversion engine: drives trial codes to an R2R ladder or PWM filter,
// samples the synchronized comparator and resolves one bit per step MSB first.
module successive_approx_controller
    import sar_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int R2R_SETTLE = R2R_SETTLE_DEFAULT,
    parameter int PWM_SETTLE = PWM_SETTLE_DEFAULT
) (
    input logic clk,
    input logic reset_n,
    successive_approx_controller_if.master bus
);

    localparam int MAX_SETTLE = (R2R_SETTLE > PWM_SETTLE) ? R2R_SETTLE : PWM_SETTLE;
    localparam int CW = $clog2(MAX_SETTLE);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] R2R_LOAD = CW'(R2R_SETTLE - 1);
    localparam logic [CW-1:0] PWM_LOAD = CW'(PWM_SETTLE - 1);
    localparam logic [IW-1:0] TOP_IDX  = IW'(WIDTH - 1);

    // The synchronizer eats two cycles of every settle window.
    if (R2R_SETTLE <= 2 || PWM_SETTLE <= 2) begin : g_bad_settle
        $error("settle counts must exceed 2");
    end

    sar_state_t       state_q, state_d;
    sar_mode_t        mode_q, mode_d, req_mode;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       sync_q;
    logic             comp;
    logic             abort;
    logic [WIDTH-1:0] duty;
    logic             pwm;

    assign comp     = sync_q[1];
    assign req_mode = pick_mode(bus.enable_r2r_successive,
                                bus.enable_pwm_successive);
    assign abort    = (state_q != S_IDLE) && (req_mode != mode_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_OFF;
            work_q   <= '0;
            dac_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            work_q   <= work_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            sync_q   <= {sync_q[0], bus.comp_in};
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        work_d   = work_q;
        dac_d    = dac_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            mode_d  = MODE_OFF;
            dac_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    dac_d = '0;
                    if (req_mode != MODE_OFF) begin
                        mode_d  = req_mode;
                        work_d  = '0;
                        idx_d   = TOP_IDX;
                        state_d = S_SET_BIT;
                    end
                end
                S_SET_BIT: begin
                    dac_d   = work_q | (WIDTH'(1) << idx_q);
                    cnt_d   = (mode_q == MODE_R2R) ? R2R_LOAD : PWM_LOAD;
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) state_d = S_SAMPLE;
                    else cnt_d = cnt_q - CW'(1);
                end
                S_SAMPLE: begin
                    // dac_q is working plus the trial bit.
                    if (comp) work_d = dac_q;
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = S_SET_BIT;
                    end
                end
                S_DONE: begin
                    result_d = work_q;
                    valid_d  = 1'b1;
                    work_d   = '0;
                    idx_d    = TOP_IDX;
                    state_d  = S_SET_BIT;
                end
                default: begin
                    state_d = S_IDLE;
                    mode_d  = MODE_OFF;
                end
            endcase
        end
    end

    assign duty = (mode_q == MODE_PWM) ? dac_q : '0;

    pwm_generator #(
        .WIDTH(WIDTH)
    ) u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .duty    (duty),
        .pwm_out (pwm)
    );

    assign bus.r2r_out      = (mode_q == MODE_R2R) ? dac_q : '0;
    assign bus.pwm_out      = pwm;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_successive_approx_controller.sv
// Scoreboard bench for the SAR engine with an ideal comparator plant.
// Expected codes and trial duties come from a bit-by-bit binary search model.
module tb_successive_approx_controller;

    localparam int W  = 8;
    localparam int RS = 4;
    localparam int PS = 8;
    localparam int RP = RS + 2;
    localparam int PP = PS + 2;
    localparam int R_LAT = 1 + W * RP;
    localparam int P_LAT = 1 + W * PP;

    typedef struct {
        logic [7:0] code;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] vin = '0;
    logic [7:0] md = '0;
    logic [7:0] pc = '0;
    logic exp_pwm = 1'b0;
    int cyc = 0;
    int checks = 0;
    int passed = 0;
    exp_t sb[$];

    bit pm_on = 1'b0;
    int pm_e0 = 0;
    logic [7:0] pm_vin = '0;

    int pw_n = 0;
    int pw_bad = 0;
    int pw_hi_dut = 0;
    int pw_hi_exp = 0;

    always #5 clk = ~clk;

    successive_approx_controller_if #(.WIDTH(W)) bus ();

    successive_approx_controller #(
        .WIDTH      (W),
        .R2R_SETTLE (RS),
        .PWM_SETTLE (PS)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // Ideal comparator: Vin >= whichever DAC is in use.
    assign bus.comp_in = (vin >= (bus.r2r_out | md));

    task automatic check(string name, int act, int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic logic [7:0] trial(logic [7:0] v, int k);
        logic [7:0] w;
        logic [7:0] b;
        w = '0;
        for (int j = 0; j < k; j++) begin
            b = 8'h80 >> j;
            if (v >= (w | b)) w = w | b;
        end
        return w | (8'h80 >> k);
    endfunction

    // Duty on the RC filter during cycle t of a PWM conversion.
    function automatic logic [7:0] duty_at(int t);
        int k;
        if (!pm_on || t < pm_e0 + 1 || t > pm_e0 + P_LAT) return '0;
        k = (t - pm_e0 - 1) / PP;
        if (k > W - 1) k = W - 1;
        return trial(pm_vin, k);
    endfunction

    always @(posedge clk) begin
        exp_pwm <= rst_n && (pc < md);
        pc      <= rst_n ? pc + 8'd1 : 8'd0;
        md      <= duty_at(cyc + 1);
        cyc     <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.result_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: result %0d at cycle %0d",
                         bus.result, cyc);
            end else begin
                e = sb.pop_front();
                check("result", int'(bus.result), int'(e.code));
                check("latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.pwm_out !== exp_pwm) pw_bad++;
        pw_hi_dut += int'(bus.pwm_out);
        pw_hi_exp += int'(exp_pwm);
        pw_n++;
        if (pw_n == 256) begin
            check("pwm_high_count", pw_hi_dut, pw_hi_exp);
            check("pwm_bad_cycles", pw_bad, 0);
            pw_n = 0;
            pw_bad = 0;
            pw_hi_dut = 0;
            pw_hi_exp = 0;
        end
    end

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int e0;
        int nz;
        logic [7:0] v;
        bus.enable_r2r_successive = 1'b0;
        bus.enable_pwm_successive = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r2r", int'(bus.r2r_out), 0);
        check("rst_pwm", int'(bus.pwm_out), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_valid", int'(bus.result_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single R2R conversion with trial-code trace.
        vin = 8'hA5;
        bus.enable_r2r_successive = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{8'hA5, e0 + R_LAT});
        for (int k = 0; k < W; k++) begin
            wait_until(e0 + 1 + RP * k);
            check("trial_code", int'(bus.r2r_out), int'(trial(8'hA5, k)));
            if (k == 0) check("busy_run", int'(bus.busy), 1);
        end
        wait_until(e0 + R_LAT);
        bus.enable_r2r_successive = 1'b0;
        wait_until(e0 + R_LAT + 3);
        check("busy_off", int'(bus.busy), 0);

        // Continuous R2R conversions: 0x00, 0xFF, then random inputs.
        vin = 8'h00;
        bus.enable_r2r_successive = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{8'h00, e0 + R_LAT});
        wait_until(e0 + R_LAT);
        vin = 8'hFF;
        sb.push_back('{8'hFF, e0 + 2 * R_LAT});
        for (int n = 2; n < 5; n++) begin
            wait_until(e0 + n * R_LAT);
            vin = 8'($urandom);
            sb.push_back('{vin, e0 + (n + 1) * R_LAT});
        end
        wait_until(e0 + 5 * R_LAT);
        bus.enable_r2r_successive = 1'b0;
        repeat (3) @(negedge clk);

        // PWM conversion; the ladder must stay quiet.
        vin = 8'h3C;
        e0 = cyc + 1;
        pm_vin = 8'h3C;
        pm_e0 = e0;
        pm_on = 1'b1;
        bus.enable_pwm_successive = 1'b1;
        sb.push_back('{8'h3C, e0 + P_LAT});
        nz = 0;
        while (cyc < e0 + P_LAT) begin
            @(negedge clk);
            if (bus.r2r_out != '0) nz++;
        end
        check("pwm_r2r_zero", nz, 0);
        bus.enable_pwm_successive = 1'b0;
        repeat (3) @(negedge clk);

        // Both enables: R2R first, then abort into PWM.
        v = 8'($urandom_range(1, 255));
        vin = v;
        bus.enable_r2r_successive = 1'b1;
        bus.enable_pwm_successive = 1'b1;
        e0 = cyc + 1;
        wait_until(e0 + 1);
        check("both_r2r", int'(bus.r2r_out), 8'h80);
        wait_until(e0 + 3);
        bus.enable_r2r_successive = 1'b0;
        pm_vin = v;
        pm_e0 = e0 + 5;
        sb.push_back('{v, e0 + 5 + P_LAT});
        wait_until(e0 + 4);
        check("abort_idle", int'(bus.busy), 0);
        wait_until(e0 + 5 + 40);
        check("abort_hold", int'(bus.result), 8'h3C);
        wait_until(e0 + 5 + P_LAT);
        bus.enable_pwm_successive = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during bit 4, then a clean conversion after release.
        v = 8'($urandom);
        vin = v;
        bus.enable_r2r_successive = 1'b1;
        e0 = cyc + 1;
        wait_until(e0 + 20);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_r2r", int'(bus.r2r_out), 0);
        check("mid_rst_pwm", int'(bus.pwm_out), 0);
        check("mid_rst_result", int'(bus.result), 0);
        check("mid_rst_valid", int'(bus.result_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{v, e0 + R_LAT});
        wait_until(e0 + R_LAT);
        bus.enable_r2r_successive = 1'b0;
        repeat (3) @(negedge clk);
        check("final_busy", int'(bus.busy), 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
